// File: rtl/switch_debounce.sv
// Mechanical switch debouncer: 2-flop synchronizer, stability counter, press/release pulses.
// Optional LED toggle-on-release output under macro SWITCH_DEBOUNCE_TOGGLE_EN.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  ,
  output logic o_Toggle
`endif
);

  localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

  state_t        r_State;
  logic          r_Sync1;
  logic          r_Sync2;
  logic [CW-1:0] r_Count;
  logic          r_Rise;
  logic          r_Fall;
  logic          w_Level;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic          r_Toggle;
`endif

  assign w_Level = (r_State == PRESSED);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State <= RELEASED;
      r_Sync1 <= 1'b0;
      r_Sync2 <= 1'b0;
      r_Count <= '0;
      r_Rise  <= 1'b0;
      r_Fall  <= 1'b0;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      r_Toggle <= 1'b0;
`endif
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
      r_Rise  <= 1'b0;
      r_Fall  <= 1'b0;
      if (r_Sync2 == w_Level) begin
        r_Count <= '0;
      end else if (r_Count != C_LAST) begin
        r_Count <= r_Count + 1'b1;
      end else begin
        // Input held the new level long enough: commit it and pulse the edge flag.
        r_Count <= '0;
        case (r_State)
          RELEASED: begin
            r_State <= PRESSED;
            r_Rise  <= 1'b1;
          end
          default: begin
            r_State <= RELEASED;
            r_Fall  <= 1'b1;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
            r_Toggle <= ~r_Toggle;
`endif
          end
        endcase
      end
    end
  end

  assign o_Switch = w_Level;
  assign o_Rise   = r_Rise;
  assign o_Fall   = r_Fall;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  assign o_Toggle = r_Toggle;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_LIMIT=4 (new level commits 5 edges after sync1 capture).
module tb_switch_debounce;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b0;
  logic i_Switch = 1'b0;
  logic o_Switch, o_Rise, o_Fall;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic o_Toggle;
`endif

  int tests  = 0;
  int errors = 0;

  switch_debounce #(.DEBOUNCE_LIMIT(4)) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Switch (i_Switch),
    .o_Switch (o_Switch),
    .o_Rise   (o_Rise),
    .o_Fall   (o_Fall)
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    ,
    .o_Toggle (o_Toggle)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset(input logic sw);
    i_Switch = sw;
    i_Rst = 1'b1;
    tick();
    tick();
    i_Rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    i_Rst = 1'b1;
    tick();
    tests++;
    if ({o_Switch, o_Rise, o_Fall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b want 000", o_Switch, o_Rise, o_Fall);
    end
    tests++;
    if (dut.r_Count !== 2'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", dut.r_Count);
    end
    i_Rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      tests++;
      if (o_Switch !== (k >= 5) || o_Rise !== (k == 5) || o_Fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_release k=%0d: sw=%b rise=%b fall=%b want sw=%b rise=%b fall=0",
                 k, o_Switch, o_Rise, o_Fall, (k >= 5), (k == 5));
      end
    end
  endtask

  task automatic test_glitch();
    do_reset(1'b0);
    i_Switch = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) i_Switch = 1'b0;
      tick();
      tests++;
      if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
        errors++;
        $display("FAIL glitch k=%0d: sw=%b rise=%b fall=%b want 000", k, o_Switch, o_Rise, o_Fall);
      end
    end
  endtask

  task automatic test_press_release();
    int nr = 0, nf = 0, ir = -1, ifl = -1, both = 0;
    do_reset(1'b0);
    for (int k = 0; k < 40; k++) begin
      i_Switch = (k < 20);
      tick();
      if (o_Rise) begin nr++; ir = k; end
      if (o_Fall) begin nf++; ifl = k; end
      if (o_Rise && o_Fall) both++;
    end
    tests++;
    if (nr !== 1 || nf !== 1) begin
      errors++;
      $display("FAIL press_release_count: rises=%0d falls=%0d want 1 1", nr, nf);
    end
    tests++;
    if (ir !== 5 || ifl !== 25) begin
      errors++;
      $display("FAIL press_release_timing: rise@%0d fall@%0d want 5 25", ir, ifl);
    end
    tests++;
    if (both !== 0 || o_Switch !== 1'b0) begin
      errors++;
      $display("FAIL press_release_final: both=%0d sw=%b want 0 0", both, o_Switch);
    end
  endtask

  task automatic test_bounce();
    int nr = 0, ir = -1, nf = 0;
    do_reset(1'b0);
    for (int k = 0; k < 30; k++) begin
      i_Switch = (k >= 16) ? 1'b1 : ((k / 2) % 2 == 0);
      tick();
      if (o_Rise) begin nr++; ir = k; end
      if (o_Fall) nf++;
    end
    tests++;
    if (nr !== 1 || ir !== 21 || nf !== 0) begin
      errors++;
      $display("FAIL bounce: rises=%0d rise@%0d falls=%0d want 1 21 0", nr, ir, nf);
    end
    tests++;
    if (o_Switch !== 1'b1) begin
      errors++;
      $display("FAIL bounce_level: got %b want 1", o_Switch);
    end
  endtask

  task automatic test_reset_mid();
    int ir = -1;
    do_reset(1'b0);
    i_Switch = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    tests++;
    if (dut.r_Count !== 2'd3 || o_Switch !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre: count=%0d sw=%b want 3 0", dut.r_Count, o_Switch);
    end
    i_Rst = 1'b1;
    tick();
    tests++;
    if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || dut.r_Count !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: sw=%b rise=%b count=%0d want 0 0 0", o_Switch, o_Rise, dut.r_Count);
    end
    i_Rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_Rise && ir < 0) ir = k;
    end
    tests++;
    if (ir !== 5 || o_Switch !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_requal: rise@%0d sw=%b want 5 1", ir, o_Switch);
    end
  endtask

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  task automatic test_toggle();
    logic prev;
    int nchg = 0;
    logic [2:0] seq = '0;
    do_reset(1'b0);
    tests++;
    if (o_Toggle !== 1'b0) begin
      errors++;
      $display("FAIL toggle_reset: got %b want 0", o_Toggle);
    end
    prev = o_Toggle;
    for (int k = 0; k < 60; k++) begin
      i_Switch = ((k % 20) < 10);
      tick();
      if (o_Toggle !== prev) begin
        tests++;
        if (o_Fall !== 1'b1) begin
          errors++;
          $display("FAIL toggle_sync k=%0d: toggle changed with fall=%b want 1", k, o_Fall);
        end
        if (nchg < 3) seq[nchg] = o_Toggle;
        nchg++;
        prev = o_Toggle;
      end
    end
    tests++;
    if (nchg !== 3 || seq !== 3'b101) begin
      errors++;
      $display("FAIL toggle_seq: changes=%0d seq=%b want 3 101", nchg, seq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_bounce();
    test_reset_mid();
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    test_toggle();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
